adder_response_checker: RTL and testbench

Hardware response checker for the adder family: consumes (operand_a, operand_b, cin, sum, cout) tuples from a stimulus source wrapped around any adder under test. It compares each result against a behavioural WIDTH+1-bit reference and reports pass/fail, error count and the first failing vector. It sits at the receiving end of the adder BIST/regression path, in silicon or in emulation.

---
 rtl/adder_chk_pkg.sv | 25 ++
 rtl/adder_response_checker_if.sv | 23 ++
 rtl/adder_chk_cmp.sv | 83 ++++++++
 rtl/adder_response_checker.sv | 245 ++++++++++++++++++++++++
 tb/tb_adder_response_checker.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_chk_pkg.sv
// Shared types and defaults for the adder response checker.
// Optional feature macro: ADDER_CHK_FIRST_ERR_EN (first-mismatch capture).
package adder_chk_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_CNT_W = 32;

   // Run-control states of the checker.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } chk_state_e;

   // One adder transaction at the default width, field order {a, b, cin, sum, cout}.
   typedef struct packed {
      logic [DEF_WIDTH-1:0] a;
      logic [DEF_WIDTH-1:0] b;
      logic                 cin;
      logic [DEF_WIDTH-1:0] sum;
      logic                 cout;
   } adder_tuple_t;

endpackage

// File: rtl/adder_response_checker_if.sv
// Tuple stream from the stimulus/adder wrapper into the checker.
// master = tuple source, slave = checker.
interface adder_response_checker_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             cin;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output in_valid, operand_a, operand_b, cin, sum, cout,
      input  in_ready
   );

   modport slave (
      input  in_valid, operand_a, operand_b, cin, sum, cout,
      output in_ready
   );
endinterface

// File: rtl/adder_chk_cmp.sv
// Registered compare stage: captures an accepted tuple, computes the full
// WIDTH+1-bit reference sum and flags a mismatch one cycle later.
// With ADDER_CHK_FIRST_ERR_EN the captured operands and values are also exported.
module adder_chk_cmp #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   input  logic [WIDTH-1:0] sum_i,
   input  logic             cout_i,
   output logic             valid_o,
   output logic             mismatch_o
`ifdef ADDER_CHK_FIRST_ERR_EN
   ,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             cin_o,
   output logic [WIDTH:0]   exp_o,
   output logic [WIDTH:0]   got_o
`endif
);

   logic [WIDTH:0] exp_s;
   logic [WIDTH:0] got_s;
   logic           valid_q;
   logic           mismatch_q;

   // Reference carry is kept: operands are zero-extended before the add.
   assign exp_s = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
   assign got_s = {cout_i, sum_i};

   // Stage occupancy and compare result for the tuple accepted this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         valid_q <= load_i;
         if (load_i) begin
            mismatch_q <= (exp_s != got_s);
         end
      end
   end

   assign valid_o    = valid_q;
   assign mismatch_o = mismatch_q;

`ifdef ADDER_CHK_FIRST_ERR_EN
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             cin_q;
   logic [WIDTH:0]   exp_q;
   logic [WIDTH:0]   got_q;

   // Keep the captured tuple so the top can record the first failing vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= {WIDTH{1'b0}};
         b_q   <= {WIDTH{1'b0}};
         cin_q <= 1'b0;
         exp_q <= {(WIDTH+1){1'b0}};
         got_q <= {(WIDTH+1){1'b0}};
      end else if (load_i) begin
         a_q   <= a_i;
         b_q   <= b_i;
         cin_q <= cin_i;
         exp_q <= exp_s;
         got_q <= got_s;
      end
   end

   assign a_o   = a_q;
   assign b_o   = b_q;
   assign cin_o = cin_q;
   assign exp_o = exp_q;
   assign got_o = got_q;
`endif

endmodule

// File: rtl/adder_response_checker.sv
// Adder response checker: accepts (a, b, cin, sum, cout) tuples, checks them
// against a WIDTH+1-bit reference, counts vectors/errors and reports pass/done.
// Optional macro ADDER_CHK_FIRST_ERR_EN builds the first-mismatch capture;
// without it the first_err_* outputs are constant zero.
module adder_response_checker
   import adder_chk_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [CNT_W-1:0]       num_vectors,
   adder_response_checker_if.slave tup,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [CNT_W-1:0]       vec_count,
   output logic [CNT_W-1:0]       err_count,
   output logic [WIDTH-1:0]       first_err_a,
   output logic [WIDTH-1:0]       first_err_b,
   output logic                   first_err_cin,
   output logic [WIDTH:0]         first_err_exp,
   output logic [WIDTH:0]         first_err_got
);

   chk_state_e       state_q;
   logic [CNT_W-1:0] num_q;
   logic [CNT_W-1:0] acc_cnt_q;
   logic             in_ready_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [CNT_W-1:0] vec_count_q, vec_count_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;

   logic             accept_s;
   logic             start_ok_s;
   logic [CNT_W-1:0] acc_next_s;
   logic             cmp_valid_s;
   logic             cmp_mismatch_s;

   assign accept_s   = tup.in_valid & in_ready_q;
   assign start_ok_s = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign acc_next_s = acc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef ADDER_CHK_FIRST_ERR_EN
   logic [WIDTH-1:0] cmp_a_s;
   logic [WIDTH-1:0] cmp_b_s;
   logic             cmp_cin_s;
   logic [WIDTH:0]   cmp_exp_s;
   logic [WIDTH:0]   cmp_got_s;
`endif

   adder_chk_cmp #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (accept_s),
      .a_i        (tup.operand_a),
      .b_i        (tup.operand_b),
      .cin_i      (tup.cin),
      .sum_i      (tup.sum),
      .cout_i     (tup.cout),
      .valid_o    (cmp_valid_s),
      .mismatch_o (cmp_mismatch_s)
`ifdef ADDER_CHK_FIRST_ERR_EN
      ,
      .a_o        (cmp_a_s),
      .b_o        (cmp_b_s),
      .cin_o      (cmp_cin_s),
      .exp_o      (cmp_exp_s),
      .got_o      (cmp_got_s)
`endif
   );

   // Run-control FSM: arms on start, accepts num_vectors tuples, drains the compare stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         num_q      <= {CNT_W{1'b0}};
         acc_cnt_q  <= {CNT_W{1'b0}};
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  num_q     <= num_vectors;
                  acc_cnt_q <= {CNT_W{1'b0}};
                  if (num_vectors == {CNT_W{1'b0}}) begin
                     // Empty run: nothing to check, report pass immediately.
                     state_q    <= ST_DONE;
                     in_ready_q <= 1'b0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                     pass_q     <= 1'b1;
                  end else begin
                     state_q    <= ST_RUN;
                     in_ready_q <= 1'b1;
                     busy_q     <= 1'b1;
                     done_q     <= 1'b0;
                     pass_q     <= 1'b0;
                  end
               end
            end
            ST_RUN: begin
               if (accept_s) begin
                  acc_cnt_q <= acc_next_s;
                  if (acc_next_s == num_q) begin
                     // Final vector taken: stop accepting on this very edge.
                     state_q    <= ST_DRAIN;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            ST_DRAIN: begin
               if (!cmp_valid_s) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_count_q == {CNT_W{1'b0}});
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
               pass_q     <= 1'b0;
            end
         endcase
      end
   end

   // Next-state of the vector and (saturating) error counters.
   always_comb begin
      vec_count_d = vec_count_q;
      err_count_d = err_count_q;
      if (start_ok_s) begin
         vec_count_d = {CNT_W{1'b0}};
         err_count_d = {CNT_W{1'b0}};
      end else if (cmp_valid_s) begin
         vec_count_d = vec_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         if (cmp_mismatch_s && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            err_count_d = err_count_q;
         end
      end else begin
         vec_count_d = vec_count_q;
         err_count_d = err_count_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_count_q <= {CNT_W{1'b0}};
         err_count_q <= {CNT_W{1'b0}};
      end else begin
         vec_count_q <= vec_count_d;
         err_count_q <= err_count_d;
      end
   end

`ifdef ADDER_CHK_FIRST_ERR_EN
   logic             first_seen_q, first_seen_d;
   logic [WIDTH-1:0] fe_a_q, fe_a_d;
   logic [WIDTH-1:0] fe_b_q, fe_b_d;
   logic             fe_cin_q, fe_cin_d;
   logic [WIDTH:0]   fe_exp_q, fe_exp_d;
   logic [WIDTH:0]   fe_got_q, fe_got_d;

   // Record only the earliest mismatch of the run; cleared when a run is armed.
   always_comb begin
      first_seen_d = first_seen_q;
      fe_a_d       = fe_a_q;
      fe_b_d       = fe_b_q;
      fe_cin_d     = fe_cin_q;
      fe_exp_d     = fe_exp_q;
      fe_got_d     = fe_got_q;
      if (start_ok_s) begin
         first_seen_d = 1'b0;
         fe_a_d       = {WIDTH{1'b0}};
         fe_b_d       = {WIDTH{1'b0}};
         fe_cin_d     = 1'b0;
         fe_exp_d     = {(WIDTH+1){1'b0}};
         fe_got_d     = {(WIDTH+1){1'b0}};
      end else if (cmp_valid_s && cmp_mismatch_s && !first_seen_q) begin
         first_seen_d = 1'b1;
         fe_a_d       = cmp_a_s;
         fe_b_d       = cmp_b_s;
         fe_cin_d     = cmp_cin_s;
         fe_exp_d     = cmp_exp_s;
         fe_got_d     = cmp_got_s;
      end else begin
         first_seen_d = first_seen_q;
      end
   end

   // First-mismatch capture registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_seen_q <= 1'b0;
         fe_a_q       <= {WIDTH{1'b0}};
         fe_b_q       <= {WIDTH{1'b0}};
         fe_cin_q     <= 1'b0;
         fe_exp_q     <= {(WIDTH+1){1'b0}};
         fe_got_q     <= {(WIDTH+1){1'b0}};
      end else begin
         first_seen_q <= first_seen_d;
         fe_a_q       <= fe_a_d;
         fe_b_q       <= fe_b_d;
         fe_cin_q     <= fe_cin_d;
         fe_exp_q     <= fe_exp_d;
         fe_got_q     <= fe_got_d;
      end
   end

   assign first_err_a   = fe_a_q;
   assign first_err_b   = fe_b_q;
   assign first_err_cin = fe_cin_q;
   assign first_err_exp = fe_exp_q;
   assign first_err_got = fe_got_q;
`else
   assign first_err_a   = {WIDTH{1'b0}};
   assign first_err_b   = {WIDTH{1'b0}};
   assign first_err_cin = 1'b0;
   assign first_err_exp = {(WIDTH+1){1'b0}};
   assign first_err_got = {(WIDTH+1){1'b0}};
`endif

   assign tup.in_ready = in_ready_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign vec_count    = vec_count_q;
   assign err_count    = err_count_q;

endmodule

// File: tb/tb_adder_response_checker.sv
// Directed testbench for adder_response_checker (32-bit operands and counters).
// First-error expectations follow ADDER_CHK_FIRST_ERR_EN: captured values when
// defined, zero otherwise.
module tb_adder_response_checker;
   import adder_chk_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] num_vectors = 32'd0;
   logic        busy, done, pass, first_err_cin;
   logic [31:0] vec_count, err_count, first_err_a, first_err_b;
   logic [32:0] first_err_exp, first_err_got;

   int n_checks = 0;
   int n_fail   = 0;

   adder_response_checker_if #(.WIDTH(32)) ifc ();

   adder_response_checker #(.WIDTH(32), .CNT_W(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .num_vectors   (num_vectors),
      .tup           (ifc),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .vec_count     (vec_count),
      .err_count     (err_count),
      .first_err_a   (first_err_a),
      .first_err_b   (first_err_b),
      .first_err_cin (first_err_cin),
      .first_err_exp (first_err_exp),
      .first_err_got (first_err_got)
   );

   always #5 clk = ~clk;

   function automatic adder_tuple_t mk(input logic [31:0] a, input logic [31:0] b,
                                       input logic ci, input logic [31:0] s, input logic co);
      adder_tuple_t t;
      t.a = a; t.b = b; t.cin = ci; t.sum = s; t.cout = co;
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [31:0] n);
      start = 1'b1;
      num_vectors = n;
      tick();
      start = 1'b0;
   endtask

   // Presents a tuple and returns 1 ns after the edge that accepted it; in_valid stays high.
   task automatic send(input adder_tuple_t t);
      bit ok;
      ok = 1'b0;
      ifc.operand_a = t.a; ifc.operand_b = t.b; ifc.cin = t.cin;
      ifc.sum = t.sum; ifc.cout = t.cout; ifc.in_valid = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (ifc.in_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL send_timeout: got no accept, required accept within 50 cycles"); end
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         cyc++;
         if (done) break;
      end
      n_checks++;
      if (!done) begin n_fail++; $display("FAIL done_timeout: got done=0, required done=1 within 40 cycles"); end
   endtask

   task automatic test_reset();
      ifc.in_valid = 1'b0; ifc.operand_a = 32'd0; ifc.operand_b = 32'd0;
      ifc.cin = 1'b0; ifc.sum = 32'd0; ifc.cout = 1'b0;
      #2;
      n_checks++;
      if ({busy, done, pass, ifc.in_ready} !== 4'b0000) begin n_fail++;
         $display("FAIL reset_flags: got %b required 0000", {busy, done, pass, ifc.in_ready}); end
      n_checks++;
      if ({vec_count, err_count} !== 64'd0) begin n_fail++;
         $display("FAIL reset_counts: got %h required 0", {vec_count, err_count}); end
      n_checks++;
      if ({first_err_a, first_err_b, first_err_cin, first_err_exp, first_err_got} !== 131'd0) begin n_fail++;
         $display("FAIL reset_first_err: got nonzero required 0"); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      n_checks++;
      if ({busy, done, ifc.in_ready} !== 3'b000) begin n_fail++;
         $display("FAIL reset_release: got %b required 000", {busy, done, ifc.in_ready}); end
   endtask

   task automatic test_correct_adder();
      adder_tuple_t v [4];
      int cyc;
      v[0] = mk(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0000_0000, 1'b1);
      v[1] = mk(32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0);
      v[2] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
      v[3] = mk(32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
      pulse_start(32'd4);
      n_checks++;
      if ({busy, ifc.in_ready, done} !== 3'b110) begin n_fail++;
         $display("FAIL correct_armed: got busy/ready/done=%b required 110", {busy, ifc.in_ready, done}); end
      for (int i = 0; i < 4; i++) send(v[i]);
      ifc.in_valid = 1'b0;
      n_checks++;
      if (ifc.in_ready !== 1'b0) begin n_fail++;
         $display("FAIL correct_ready_drop: got %b required 0", ifc.in_ready); end
      wait_done(cyc);
      n_checks++;
      if (cyc !== 2) begin n_fail++; $display("FAIL correct_done_latency: got %0d required 2", cyc); end
      n_checks++;
      if (vec_count !== 32'd4) begin n_fail++; $display("FAIL correct_vec: got %0d required 4", vec_count); end
      n_checks++;
      if (err_count !== 32'd0) begin n_fail++; $display("FAIL correct_err: got %0d required 0", err_count); end
      n_checks++;
      if ({pass, busy} !== 2'b10) begin n_fail++; $display("FAIL correct_pass: got pass/busy=%b required 10", {pass, busy}); end
   endtask

   task automatic test_carry_loss();
      int cyc;
      logic [32:0] exp_exp;
      logic [31:0] exp_a;
`ifdef ADDER_CHK_FIRST_ERR_EN
      exp_exp = 33'h1_0000_0000; exp_a = 32'hFFFF_FFFF;
`else
      exp_exp = 33'h0; exp_a = 32'h0;
`endif
      pulse_start(32'd1);
      send(mk(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b0));
      ifc.in_valid = 1'b0;
      wait_done(cyc);
      n_checks++;
      if (cyc !== 2) begin n_fail++; $display("FAIL carry_done_latency: got %0d required 2", cyc); end
      n_checks++;
      if (err_count !== 32'd1) begin n_fail++; $display("FAIL carry_err: got %0d required 1", err_count); end
      n_checks++;
      if (pass !== 1'b0) begin n_fail++; $display("FAIL carry_pass: got %b required 0", pass); end
      n_checks++;
      if (first_err_exp !== exp_exp) begin n_fail++;
         $display("FAIL carry_first_exp: got %h required %h", first_err_exp, exp_exp); end
      n_checks++;
      if (first_err_got !== 33'h0) begin n_fail++;
         $display("FAIL carry_first_got: got %h required 0", first_err_got); end
      n_checks++;
      if (first_err_a !== exp_a) begin n_fail++;
         $display("FAIL carry_first_a: got %h required %h", first_err_a, exp_a); end
   endtask

   task automatic test_three_errors();
      adder_tuple_t v [10];
      int cyc;
      logic [31:0] ea, eb;
      logic        ec;
      logic [32:0] ee;
      v[0] = mk(32'd1, 32'd2, 1'b0, 32'd3, 1'b0);
      v[1] = mk(32'd10, 32'd20, 1'b1, 32'd31, 1'b0);
      v[2] = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b0);
      v[3] = mk(32'd5, 32'd5, 1'b0, 32'd10, 1'b0);
      v[4] = mk(32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1);
      v[5] = mk(32'h100, 32'h200, 1'b0, 32'h301, 1'b0);
      v[6] = mk(32'h0, 32'h0, 1'b1, 32'h1, 1'b0);
      v[7] = mk(32'h1234, 32'h1, 1'b0, 32'h1235, 1'b1);
      v[8] = mk(32'hFFFF, 32'h1, 1'b0, 32'h1_0000, 1'b0);
      v[9] = mk(32'd2, 32'd2, 1'b1, 32'd5, 1'b0);
`ifdef ADDER_CHK_FIRST_ERR_EN
      ea = 32'h8000_0000; eb = 32'h8000_0000; ec = 1'b0; ee = 33'h1_0000_0000;
`else
      ea = 32'h0; eb = 32'h0; ec = 1'b0; ee = 33'h0;
`endif
      pulse_start(32'd10);
      for (int i = 0; i < 10; i++) send(v[i]);
      ifc.in_valid = 1'b0;
      wait_done(cyc);
      n_checks++;
      if (err_count !== 32'd3) begin n_fail++; $display("FAIL three_err: got %0d required 3", err_count); end
      n_checks++;
      if (vec_count !== 32'd10) begin n_fail++; $display("FAIL three_vec: got %0d required 10", vec_count); end
      n_checks++;
      if ({first_err_a, first_err_b, first_err_cin} !== {ea, eb, ec}) begin n_fail++;
         $display("FAIL three_first_ops: got %h %h %b required %h %h %b",
                  first_err_a, first_err_b, first_err_cin, ea, eb, ec); end
      n_checks++;
      if ({first_err_exp, first_err_got} !== {ee, 33'h0}) begin n_fail++;
         $display("FAIL three_first_vals: got %h %h required %h 0", first_err_exp, first_err_got, ee); end
      n_checks++;
      if (pass !== 1'b0) begin n_fail++; $display("FAIL three_pass: got %b required 0", pass); end
   endtask

   task automatic test_valid_toggle();
      int cyc;
      pulse_start(32'd5);
      for (int i = 0; i < 5; i++) begin
         send(mk(i, i, 1'b0, 2 * i, 1'b0));
         ifc.in_valid = 1'b0;
         if (i == 4) begin
            n_checks++;
            if (ifc.in_ready !== 1'b0) begin n_fail++;
               $display("FAIL toggle_ready_drop: got %b required 0", ifc.in_ready); end
         end
         tick();
      end
      // A sixth, deliberately wrong tuple must be left untouched.
      ifc.operand_a = 32'd7; ifc.operand_b = 32'd7; ifc.cin = 1'b0;
      ifc.sum = 32'd99; ifc.cout = 1'b0; ifc.in_valid = 1'b1;
      wait_done(cyc);
      repeat (3) tick();
      n_checks++;
      if (vec_count !== 32'd5) begin n_fail++; $display("FAIL toggle_vec: got %0d required 5", vec_count); end
      n_checks++;
      if ({err_count, pass, ifc.in_ready} !== {32'd0, 1'b1, 1'b0}) begin n_fail++;
         $display("FAIL toggle_no_consume: got err=%0d pass=%b ready=%b required 0 1 0", err_count, pass, ifc.in_ready); end
      n_checks++;
      if (first_err_a !== 32'h0) begin n_fail++;
         $display("FAIL toggle_first_cleared: got %h required 0", first_err_a); end
      ifc.in_valid = 1'b0;
   endtask

   task automatic test_zero_and_ignored_start();
      int cyc;
      pulse_start(32'd0);
      n_checks++;
      if ({done, pass, busy} !== 3'b110) begin n_fail++;
         $display("FAIL zero_flags: got done/pass/busy=%b required 110", {done, pass, busy}); end
      n_checks++;
      if ({vec_count, err_count} !== 64'd0) begin n_fail++;
         $display("FAIL zero_counts: got %h required 0", {vec_count, err_count}); end
      pulse_start(32'd4);
      send(mk(32'd3, 32'd4, 1'b0, 32'd7, 1'b0));
      send(mk(32'd3, 32'd4, 1'b0, 32'd8, 1'b0));
      ifc.in_valid = 1'b0;
      pulse_start(32'd0);
      n_checks++;
      if ({busy, ifc.in_ready, done} !== 3'b110) begin n_fail++;
         $display("FAIL ign_flags: got busy/ready/done=%b required 110", {busy, ifc.in_ready, done}); end
      n_checks++;
      if ({vec_count, err_count} !== {32'd2, 32'd1}) begin n_fail++;
         $display("FAIL ign_counts: got vec=%0d err=%0d required 2 1", vec_count, err_count); end
      send(mk(32'd1, 32'd1, 1'b1, 32'd3, 1'b0));
      send(mk(32'd0, 32'd0, 1'b0, 32'd0, 1'b0));
      ifc.in_valid = 1'b0;
      wait_done(cyc);
      n_checks++;
      if ({vec_count, err_count, pass} !== {32'd4, 32'd1, 1'b0}) begin n_fail++;
         $display("FAIL ign_final: got vec=%0d err=%0d pass=%b required 4 1 0", vec_count, err_count, pass); end
   endtask

   task automatic test_async_reset();
      int cyc;
      pulse_start(32'd8);
      send(mk(32'd1, 32'd1, 1'b0, 32'd2, 1'b0));
      send(mk(32'd1, 32'd1, 1'b0, 32'd9, 1'b0));
      send(mk(32'd2, 32'd2, 1'b0, 32'd4, 1'b0));
      ifc.in_valid = 1'b0;
      n_checks++;
      if ({vec_count, err_count} !== {32'd2, 32'd1}) begin n_fail++;
         $display("FAIL arst_before: got vec=%0d err=%0d required 2 1", vec_count, err_count); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, pass, ifc.in_ready} !== 4'b0000) begin n_fail++;
         $display("FAIL arst_flags: got %b required 0000", {busy, done, pass, ifc.in_ready}); end
      n_checks++;
      if ({vec_count, err_count} !== 64'd0) begin n_fail++;
         $display("FAIL arst_counts: got vec=%0d err=%0d required 0 0", vec_count, err_count); end
      n_checks++;
      if ({first_err_a, first_err_exp} !== 65'd0) begin n_fail++;
         $display("FAIL arst_first_err: got %h %h required 0", first_err_a, first_err_exp); end
      #2 rst_n = 1'b1;
      tick();
      pulse_start(32'd2);
      send(mk(32'h1000, 32'h0FFF, 1'b1, 32'h2000, 1'b0));
      send(mk(32'hFFFF_FFFE, 32'h1, 1'b1, 32'h0, 1'b1));
      ifc.in_valid = 1'b0;
      wait_done(cyc);
      n_checks++;
      if ({vec_count, err_count, pass} !== {32'd2, 32'd0, 1'b1}) begin n_fail++;
         $display("FAIL arst_fresh_run: got vec=%0d err=%0d pass=%b required 2 0 1", vec_count, err_count, pass); end
   endtask

   initial begin
      test_reset();
      test_correct_adder();
      test_carry_loss();
      test_three_errors();
      test_valid_toggle();
      test_zero_and_ignored_start();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
